aabb_microcode_engine: RTL and testbench

//  Parametrised microcoded slab-test engine for ray/AABB intersection in the GPU core.

---
 rtl/aabb_microcode_engine.sv | 217 +++++++++++++++++++++
 tb/tb_aabb_microcode_engine.sv | 459 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aabb_microcode_engine.sv
// Microcoded ray/AABB slab-test engine: host-loaded program over a small
// fixed-point register file, fed by a show-ahead input FIFO.
module aabb_microcode_engine #(
    parameter int DATA_W      = 32,
    parameter int FRAC_BITS   = 16,
    parameter int REG_ADDR_W  = 3,
    parameter int INSN_ADDR_W = 5
) (
    input  logic                   iClock,
    input  logic                   iReset,
    input  logic                   iStart,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oHit,
    output logic                   oError,
    input  logic                   iCfgWrite,
    input  logic                   iCfgInsn,
    input  logic [INSN_ADDR_W-1:0] iCfgAddr,
    input  logic [DATA_W-1:0]      iCfgData,
    output logic [DATA_W-1:0]      oCfgData,
    input  logic                   iFifoEmpty,
    input  logic [DATA_W-1:0]      iFifoData,
    output logic                   oFifoPop
);

    localparam int INSN_W = 4 + 3 * REG_ADDR_W;
    localparam int NREG   = 2 ** REG_ADDR_W;
    localparam int NINSN  = 2 ** INSN_ADDR_W;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_MUL   = 4'd2;
    localparam logic [3:0] OP_MIN   = 4'd3;
    localparam logic [3:0] OP_MAX   = 4'd4;
    localparam logic [3:0] OP_POP   = 4'd5;
    localparam logic [3:0] OP_RGT   = 4'd6;
    localparam logic [3:0] OP_RLT   = 4'd7;
    localparam logic [3:0] OP_RTRUE = 4'd8;
    localparam logic [3:0] OP_RFALSE = 4'd9;

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t                 state_q, state_d;
    logic [INSN_ADDR_W-1:0] ip_q, ip_d;
    logic                   done_q, done_d;
    logic                   hit_q, hit_d;
    logic                   err_q, err_d;

    logic [INSN_W-1:0] imem [NINSN];
    logic [DATA_W-1:0] rf   [NREG];

    logic [INSN_W-1:0]     insn;
    logic [3:0]            op;
    logic [REG_ADDR_W-1:0] dst, src_a, src_b;
    logic [DATA_W-1:0]     a, b;
    logic                  a_lt_b, a_gt_b;

    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]          mul_res;
    logic                       unused_prod;

    logic              ex_we, cfg_we;
    logic [DATA_W-1:0] ex_wdata;
    logic              adv, fin, fin_hit, fin_err;

    assign insn  = imem[ip_q];
    assign op    = insn[INSN_W-1 -: 4];
    assign dst   = insn[3*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src_a = insn[2*REG_ADDR_W-1 -: REG_ADDR_W];
    assign src_b = insn[REG_ADDR_W-1:0];
    assign a     = rf[src_a];
    assign b     = rf[src_b];

    assign a_lt_b = $signed(a) < $signed(b);
    assign a_gt_b = $signed(a) > $signed(b);

    // Full-width signed product; the kept window equals (A*B) >>> FRAC_BITS.
    assign prod = $signed({{DATA_W{a[DATA_W-1]}}, a})
                * $signed({{DATA_W{b[DATA_W-1]}}, b});
    assign mul_res     = prod[FRAC_BITS +: DATA_W];
    assign unused_prod = ^{prod[2*DATA_W-1 -: (DATA_W-FRAC_BITS)],
                           prod[FRAC_BITS-1:0]};

    assign cfg_we = iCfgWrite && (state_q == S_IDLE);

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q <= S_IDLE;
            ip_q    <= '0;
            done_q  <= 1'b0;
            hit_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            done_q  <= done_d;
            hit_q   <= hit_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ip_d     = ip_q;
        done_d   = 1'b0;
        hit_d    = hit_q;
        err_d    = err_q;
        ex_we    = 1'b0;
        ex_wdata = '0;
        adv      = 1'b0;
        fin      = 1'b0;
        fin_hit  = 1'b0;
        fin_err  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (iStart) begin
                    state_d = S_RUN;
                    ip_d    = '0;
                    hit_d   = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                unique case (op)
                    OP_NOP: adv = 1'b1;
                    OP_SUB: begin
                        ex_we    = 1'b1;
                        ex_wdata = a - b;
                        adv      = 1'b1;
                    end
                    OP_MUL: begin
                        ex_we    = 1'b1;
                        ex_wdata = mul_res;
                        adv      = 1'b1;
                    end
                    OP_MIN: begin
                        ex_we    = 1'b1;
                        ex_wdata = a_lt_b ? a : b;
                        adv      = 1'b1;
                    end
                    OP_MAX: begin
                        ex_we    = 1'b1;
                        ex_wdata = a_gt_b ? a : b;
                        adv      = 1'b1;
                    end
                    OP_POP: begin
                        if (!iFifoEmpty) begin
                            ex_we    = 1'b1;
                            ex_wdata = iFifoData;
                            adv      = 1'b1;
                        end
                    end
                    OP_RGT: begin
                        fin = a_gt_b;
                        adv = !a_gt_b;
                    end
                    OP_RLT: begin
                        fin = a_lt_b;
                        adv = !a_lt_b;
                    end
                    OP_RTRUE: begin
                        fin     = 1'b1;
                        fin_hit = 1'b1;
                    end
                    OP_RFALSE: fin = 1'b1;
                    default: begin
                        fin     = 1'b1;
                        fin_err = 1'b1;
                    end
                endcase
                // Running off the end of the RAM is an error, never a wrap.
                if (adv && (&ip_q)) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end else if (adv) begin
                    ip_d = ip_q + INSN_ADDR_W'(1);
                end
                if (fin) begin
                    state_d = S_IDLE;
                    ip_d    = '0;
                    done_d  = 1'b1;
                    hit_d   = fin_hit;
                    err_d   = fin_err;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        oBusy    = (state_q == S_RUN);
        oFifoPop = (state_q == S_RUN) && (op == OP_POP) && !iFifoEmpty;
    end

    always_ff @(posedge iClock) begin
        if (cfg_we && iCfgInsn) begin
            imem[iCfgAddr] <= iCfgData[INSN_W-1:0];
        end
    end

    always_ff @(posedge iClock) begin
        if (cfg_we && !iCfgInsn) begin
            rf[iCfgAddr[REG_ADDR_W-1:0]] <= iCfgData;
        end else if (ex_we) begin
            rf[dst] <= ex_wdata;
        end
    end

    assign oCfgData = iCfgInsn
                    ? {{(DATA_W-INSN_W){1'b0}}, imem[iCfgAddr]}
                    : rf[iCfgAddr[REG_ADDR_W-1:0]];

    assign oDone  = done_q;
    assign oHit   = hit_q;
    assign oError = err_q;

endmodule

// File: tb/tb_aabb_microcode_engine.sv
// Directed bench for aabb_microcode_engine: arithmetic, FIFO stall,
// slab program, abnormal ends, host/start interaction and async reset.
module tb_aabb_microcode_engine;

    logic        iClock = 1'b0;
    logic        iReset = 1'b0;
    logic        iStart = 1'b0;
    logic        oBusy, oDone, oHit, oError;
    logic        iCfgWrite = 1'b0;
    logic        iCfgInsn = 1'b0;
    logic [4:0]  iCfgAddr = '0;
    logic [31:0] iCfgData = '0;
    logic [31:0] oCfgData;
    logic        iFifoEmpty;
    logic [31:0] iFifoData;
    logic        oFifoPop;

    int vecs = 0;
    int errs = 0;

    logic [31:0] fifo_mem [64];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    int          pops = 0;
    logic        hold = 1'b0;

    localparam logic [3:0] NOP = 4'd0, SUB = 4'd1, MUL = 4'd2, MIN = 4'd3;
    localparam logic [3:0] MAX = 4'd4, POP = 4'd5, RGT = 4'd6, RLT = 4'd7;
    localparam logic [3:0] RTRUE = 4'd8, RFALSE = 4'd9;

    aabb_microcode_engine dut (
        .iClock(iClock), .iReset(iReset), .iStart(iStart),
        .oBusy(oBusy), .oDone(oDone), .oHit(oHit), .oError(oError),
        .iCfgWrite(iCfgWrite), .iCfgInsn(iCfgInsn),
        .iCfgAddr(iCfgAddr), .iCfgData(iCfgData), .oCfgData(oCfgData),
        .iFifoEmpty(iFifoEmpty), .iFifoData(iFifoData), .oFifoPop(oFifoPop)
    );

    always #5 iClock = ~iClock;

    assign iFifoEmpty = hold || (rd_ptr == wr_ptr);
    assign iFifoData  = fifo_mem[rd_ptr % 64];

    always @(posedge iClock) begin
        if (oFifoPop) begin
            rd_ptr <= rd_ptr + 1;
            pops   <= pops + 1;
        end
    end

    function automatic logic [12:0] enc(input logic [3:0] op,
                                        input logic [2:0] d,
                                        input logic [2:0] sa,
                                        input logic [2:0] sb);
        return {op, d, sa, sb};
    endfunction

    task automatic push(input logic [31:0] d);
        fifo_mem[wr_ptr % 64] = d;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic cfg_wr(input logic ins, input logic [4:0] addr,
                          input logic [31:0] data);
        @(negedge iClock);
        iCfgWrite = 1'b1;
        iCfgInsn  = ins;
        iCfgAddr  = addr;
        iCfgData  = data;
        @(posedge iClock);
        #1 iCfgWrite = 1'b0;
    endtask

    task automatic wr_insn(input logic [4:0] addr, input logic [12:0] w);
        cfg_wr(1'b1, addr, {19'd0, w});
    endtask

    task automatic wr_reg(input logic [4:0] addr, input logic [31:0] d);
        cfg_wr(1'b0, addr, d);
    endtask

    task automatic cfg_rd(input logic ins, input logic [4:0] addr,
                          output logic [31:0] d);
        @(negedge iClock);
        iCfgInsn = ins;
        iCfgAddr = addr;
        #1 d = oCfgData;
    endtask

    // Returns edges from start acceptance to oDone, or -1 on timeout.
    task automatic run(input int budget, output int cyc);
        @(negedge iClock);
        iStart = 1'b1;
        @(posedge iClock);
        #1 iStart = 1'b0;
        cyc = -1;
        for (int i = 1; i <= budget; i++) begin
            @(posedge iClock);
            #1;
            if (oDone) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [4:0] o;
        repeat (3) @(posedge iClock);
        #1 o = {oBusy, oDone, oHit, oError, oFifoPop};
        vecs++;
        if (o !== 5'b0) begin
            errs++;
            $display("FAIL reset_held: got %b want 00000", o);
        end
        @(negedge iClock);
        iReset = 1'b1;
        @(posedge iClock);
        #1 o = {oBusy, oDone, oHit, oError, oFifoPop};
        vecs++;
        if (o !== 5'b0) begin
            errs++;
            $display("FAIL reset_release: got %b want 00000", o);
        end
    endtask

    task automatic test_sub();
        int cyc;
        logic [31:0] d;
        wr_reg(0, 32'd5);
        wr_reg(1, 32'd7);
        wr_insn(0, enc(SUB, 2, 0, 1));
        wr_insn(1, enc(RTRUE, 0, 0, 0));
        run(20, cyc);
        vecs++;
        if (cyc !== 2 || oHit !== 1'b1 || oError !== 1'b0) begin
            errs++;
            $display("FAIL sub_done: got cyc=%0d hit=%b err=%b want 2 1 0",
                     cyc, oHit, oError);
        end
        @(posedge iClock);
        #1;
        vecs++;
        if (oDone !== 1'b0 || oBusy !== 1'b0) begin
            errs++;
            $display("FAIL done_pulse: got done=%b busy=%b want 0 0",
                     oDone, oBusy);
        end
        cfg_rd(1'b0, 2, d);
        vecs++;
        if (d !== 32'hFFFF_FFFE) begin
            errs++;
            $display("FAIL sub_r2: got %h want fffffffe", d);
        end
        // dst aliasing a source, result consumed by the next instruction
        wr_insn(0, enc(SUB, 0, 0, 1));
        wr_insn(1, enc(SUB, 3, 0, 1));
        wr_insn(2, enc(RTRUE, 0, 0, 0));
        run(20, cyc);
        cfg_rd(1'b0, 3, d);
        vecs++;
        if (cyc !== 3 || d !== 32'hFFFF_FFF7) begin
            errs++;
            $display("FAIL sub_chain: got cyc=%0d r3=%h want 3 fffffff7",
                     cyc, d);
        end
    endtask

    task automatic test_mul();
        int cyc;
        logic [31:0] d;
        wr_reg(0, 32'h0001_8000);
        wr_reg(1, 32'hFFFE_0000);
        wr_insn(0, enc(MUL, 2, 0, 1));
        wr_insn(1, enc(MUL, 3, 0, 0));
        wr_insn(2, enc(RTRUE, 0, 0, 0));
        run(20, cyc);
        cfg_rd(1'b0, 2, d);
        vecs++;
        if (d !== 32'hFFFD_0000) begin
            errs++;
            $display("FAIL mul_neg: got %h want fffd0000", d);
        end
        cfg_rd(1'b0, 3, d);
        vecs++;
        if (d !== 32'h0002_4000) begin
            errs++;
            $display("FAIL mul_sq: got %h want 00024000", d);
        end
    endtask

    task automatic test_minmax();
        int cyc;
        logic [31:0] d2, d3;
        wr_reg(0, 32'hFFFF_FFFB);
        wr_reg(1, 32'd3);
        wr_insn(0, enc(MIN, 2, 0, 1));
        wr_insn(1, enc(MAX, 3, 0, 1));
        wr_insn(2, enc(RGT, 0, 0, 1));
        wr_insn(3, enc(RLT, 0, 0, 1));
        wr_insn(4, enc(RTRUE, 0, 0, 0));
        run(20, cyc);
        vecs++;
        if (cyc !== 4 || oHit !== 1'b0 || oError !== 1'b0) begin
            errs++;
            $display("FAIL ret_lt: got cyc=%0d hit=%b err=%b want 4 0 0",
                     cyc, oHit, oError);
        end
        cfg_rd(1'b0, 2, d2);
        cfg_rd(1'b0, 3, d3);
        vecs++;
        if (d2 !== 32'hFFFF_FFFB || d3 !== 32'd3) begin
            errs++;
            $display("FAIL minmax: got %h %h want fffffffb 00000003", d2, d3);
        end
    endtask

    task automatic test_pop_stall();
        int p0;
        logic [31:0] d;
        wr_insn(0, enc(POP, 3, 0, 0));
        wr_insn(1, enc(RTRUE, 0, 0, 0));
        hold = 1'b1;
        push(32'h0000_1234);
        p0 = pops;
        @(negedge iClock);
        iStart = 1'b1;
        @(posedge iClock);
        #1 iStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge iClock);
                #1;
            end
            vecs++;
            if (oFifoPop !== 1'b0 || oBusy !== 1'b1 || oDone !== 1'b0) begin
                errs++;
                $display("FAIL stall_%0d: got pop=%b busy=%b done=%b want 0 1 0",
                         i, oFifoPop, oBusy, oDone);
            end
        end
        hold = 1'b0;
        #1;
        vecs++;
        if (oFifoPop !== 1'b1) begin
            errs++;
            $display("FAIL pop_strobe: got %b want 1", oFifoPop);
        end
        @(posedge iClock);
        #1;
        vecs++;
        if (oDone !== 1'b0 || oFifoPop !== 1'b0) begin
            errs++;
            $display("FAIL pop_advance: got done=%b pop=%b want 0 0",
                     oDone, oFifoPop);
        end
        @(posedge iClock);
        #1;
        vecs++;
        if (oDone !== 1'b1 || oHit !== 1'b1 || pops - p0 !== 1) begin
            errs++;
            $display("FAIL pop_end: got done=%b hit=%b pops=%0d want 1 1 1",
                     oDone, oHit, pops - p0);
        end
        cfg_rd(1'b0, 3, d);
        vecs++;
        if (d !== 32'h0000_1234) begin
            errs++;
            $display("FAIL pop_r3: got %h want 00001234", d);
        end
    endtask

    task automatic load_slab_regs();
        wr_reg(0, 32'h0000_0000);
        wr_reg(1, 32'h7FFF_FFFF);
        wr_reg(5, 32'h0001_0000);
        wr_reg(6, 32'h0001_0000);
        wr_reg(7, 32'h0001_0000);
    endtask

    task automatic test_slab();
        int cyc;
        logic [31:0] org;
        org = 32'h0;
        for (int k = 0; k < 3; k++) begin
            wr_insn(5'(8*k + 0), enc(POP, 3, 0, 0));
            wr_insn(5'(8*k + 1), enc(POP, 4, 0, 0));
            wr_insn(5'(8*k + 2), enc(MUL, 3, 3, 3'(5 + k)));
            wr_insn(5'(8*k + 3), enc(MUL, 4, 4, 3'(5 + k)));
            wr_insn(5'(8*k + 4), enc(MIN, 2, 3, 4));
            wr_insn(5'(8*k + 5), enc(MAX, 3, 3, 4));
            wr_insn(5'(8*k + 6), enc(MAX, 0, 0, 2));
            wr_insn(5'(8*k + 7), enc(MIN, 1, 1, 3));
        end
        wr_insn(24, enc(RGT, 0, 0, 1));
        wr_insn(25, enc(RTRUE, 0, 0, 0));
        load_slab_regs();
        for (int k = 0; k < 3; k++) begin
            push(32'h0001_0000 - org);
            push(32'h0002_0000 - org);
        end
        run(100, cyc);
        vecs++;
        if (cyc !== 26 || oHit !== 1'b1 || oError !== 1'b0) begin
            errs++;
            $display("FAIL slab_hit: got cyc=%0d hit=%b err=%b want 26 1 0",
                     cyc, oHit, oError);
        end
        load_slab_regs();
        for (int k = 0; k < 3; k++) begin
            push(32'hFFFD_0000 - org);
            push(32'hFFFF_0000 - org);
        end
        run(100, cyc);
        vecs++;
        if (cyc !== 25 || oHit !== 1'b0 || oError !== 1'b0) begin
            errs++;
            $display("FAIL slab_miss: got cyc=%0d hit=%b err=%b want 25 0 0",
                     cyc, oHit, oError);
        end
    endtask

    task automatic test_end_of_ram();
        int cyc;
        for (int i = 0; i < 32; i++) wr_insn(5'(i), enc(NOP, 0, 0, 0));
        run(60, cyc);
        vecs++;
        if (cyc !== 32 || oError !== 1'b1 || oHit !== 1'b0) begin
            errs++;
            $display("FAIL nop_run: got cyc=%0d err=%b hit=%b want 32 1 0",
                     cyc, oError, oHit);
        end
    endtask

    task automatic test_illegal();
        int cyc;
        wr_insn(0, enc(4'd12, 0, 0, 0));
        run(20, cyc);
        vecs++;
        if (cyc !== 1 || oError !== 1'b1 || oHit !== 1'b0) begin
            errs++;
            $display("FAIL illegal: got cyc=%0d err=%b hit=%b want 1 1 0",
                     cyc, oError, oHit);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        wr_insn(0, enc(RTRUE, 0, 0, 0));
        run(20, cyc);
        vecs++;
        if (cyc !== 1 || oHit !== 1'b1 || oError !== 1'b0) begin
            errs++;
            $display("FAIL ret_true: got cyc=%0d hit=%b err=%b want 1 1 0",
                     cyc, oHit, oError);
        end
        @(negedge iClock);
        iStart    = 1'b1;
        iCfgWrite = 1'b1;
        iCfgInsn  = 1'b1;
        iCfgAddr  = 5'd0;
        iCfgData  = {19'd0, enc(RFALSE, 0, 0, 0)};
        @(posedge iClock);
        #1;
        iStart    = 1'b0;
        iCfgWrite = 1'b0;
        cyc = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge iClock);
            #1;
            if (oDone) begin
                cyc = i;
                break;
            end
        end
        vecs++;
        if (cyc !== 1 || oHit !== 1'b0) begin
            errs++;
            $display("FAIL write_with_start: got cyc=%0d hit=%b want 1 0",
                     cyc, oHit);
        end
    endtask

    task automatic test_run_write_and_reset();
        int p0;
        logic [31:0] d;
        bit bad;
        wr_reg(4, 32'h0000_1111);
        wr_insn(0, enc(POP, 3, 0, 0));
        wr_insn(1, enc(RTRUE, 0, 0, 0));
        hold = 1'b1;
        push(32'h0000_ABCD);
        p0 = pops;
        @(negedge iClock);
        iStart = 1'b1;
        @(posedge iClock);
        #1 iStart = 1'b0;
        wr_reg(4, 32'h0000_DEAD);
        wr_insn(1, enc(RFALSE, 0, 0, 0));
        vecs++;
        if (oBusy !== 1'b1) begin
            errs++;
            $display("FAIL stall_busy: got %b want 1", oBusy);
        end
        @(negedge iClock);
        iReset = 1'b0;
        #1;
        vecs++;
        if (oBusy !== 1'b0 || oFifoPop !== 1'b0 || oDone !== 1'b0) begin
            errs++;
            $display("FAIL mid_reset: got busy=%b pop=%b done=%b want 0 0 0",
                     oBusy, oFifoPop, oDone);
        end
        hold = 1'b0;
        @(negedge iClock);
        iReset = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge iClock);
            #1;
            if (oFifoPop !== 1'b0 || oDone !== 1'b0 || oBusy !== 1'b0) bad = 1'b1;
        end
        vecs++;
        if (bad || pops !== p0) begin
            errs++;
            $display("FAIL after_reset: got bad=%b pops=%0d want 0 0",
                     bad, pops - p0);
        end
        cfg_rd(1'b0, 4, d);
        vecs++;
        if (d !== 32'h0000_1111) begin
            errs++;
            $display("FAIL run_reg_write: got %h want 00001111", d);
        end
        cfg_rd(1'b1, 1, d);
        vecs++;
        if (d !== {19'd0, enc(RTRUE, 0, 0, 0)}) begin
            errs++;
            $display("FAIL run_insn_write: got %h want %h",
                     d, {19'd0, enc(RTRUE, 0, 0, 0)});
        end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_mul();
        test_minmax();
        test_pop_stall();
        test_slab();
        test_end_of_ram();
        test_illegal();
        test_back_to_back();
        test_run_write_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
